slot_judge: RTL and testbench

SLOT_JUDGE -- requirements
Module: slot_judge

---
 rtl/slot_judge.sv | 143 ++++++++++++++
 tb/tb_slot_judge.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/slot_judge.sv
// -----------------------------------------------------------------------------
// slot_judge
//   Slot machine game controller. Accepts a start pulse when credits remain and
//   charges one credit. Waits for all three reels to stop and stay stopped for
//   SETTLE_CYCLES cycles, then compares the reel patterns. It scores the game,
//   pays out credits and blinks a win indicator while the result is shown.
//
// Ports
//   clk       : system clock, rising edge
//   reset_n   : synchronous active-low reset
//   start     : one-cycle debounced game-start pulse
//   reel_run  : bit i high while reel i is spinning
//   reel0..2  : current 8-bit LED pattern of each reel
//   busy      : high while a game is in progress (SPIN, SETTLE, JUDGE)
//   result    : 0 = lose, 1 = pair, 2 = triple
//   win_led   : blinking win indicator, only active in SHOW
//   credits   : current credit count
// -----------------------------------------------------------------------------
module slot_judge #(
  parameter int SETTLE_CYCLES = 4,
  parameter int BLINK_BITS    = 24,
  parameter int INIT_CREDITS  = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [2:0] reel_run,
  input  logic [7:0] reel0,
  input  logic [7:0] reel1,
  input  logic [7:0] reel2,
  output logic       busy,
  output logic [1:0] result,
  output logic       win_led,
  output logic [7:0] credits
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SPIN   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_JUDGE  = 3'd3;
  localparam logic [2:0] ST_SHOW   = 3'd4;

  localparam logic [1:0] RES_LOSE   = 2'd0;
  localparam logic [1:0] RES_PAIR   = 2'd1;
  localparam logic [1:0] RES_TRIPLE = 2'd2;

  // The counter never needs to hold more than SETTLE_CYCLES-1.
  localparam int              CW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  logic [2:0]            state;
  logic [CW-1:0]         settle_cnt;
  logic [CW-1:0]         settle_next;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic                  blink_wrap;
  logic [1:0]            judge_result;
  logic [2:0]            bonus;
  logic [8:0]            credit_sum;
  logic [7:0]            credits_paid;

  assign busy = (state == ST_SPIN) || (state == ST_SETTLE) || (state == ST_JUDGE);

  // The SPIN cycle that first sees all reels stopped counts as the first
  // stopped cycle. So SETTLE leaves when the incremented count reaches
  // SETTLE_CYCLES-1, which places SHOW entry SETTLE_CYCLES+1 edges after that
  // first stopped cycle.
  assign settle_next = settle_cnt + CW'(1);
  assign blink_wrap  = &blink_cnt;

  // Score the reels and compute the saturating payout.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    judge_result = RES_LOSE;
    bonus        = 3'd0;
    if ((reel0 == reel1) && (reel1 == reel2)) begin
      judge_result = RES_TRIPLE;
      bonus        = 3'd5;
    end else if ((reel0 == reel1) || (reel1 == reel2) || (reel0 == reel2)) begin
      judge_result = RES_PAIR;
      bonus        = 3'd1;
    end
    credit_sum   = {1'b0, credits} + {6'd0, bonus};
    credits_paid = credit_sum[8] ? 8'hFF : credit_sum[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      credits    <= 8'(INIT_CREDITS);
      result     <= RES_LOSE;
      win_led    <= 1'b0;
      settle_cnt <= '0;
      blink_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_SHOW: begin
          if (start && (credits != 8'd0)) begin
            state     <= ST_SPIN;
            credits   <= credits - 8'd1;
            result    <= RES_LOSE;
            win_led   <= 1'b0;
            blink_cnt <= '0;
          end else if (state == ST_SHOW) begin
            blink_cnt <= blink_cnt + BLINK_BITS'(1);
            if (blink_wrap && (result != RES_LOSE)) begin
              win_led <= ~win_led;
            end
          end
        end

        ST_SPIN: begin
          if (reel_run == 3'b000) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
          end
        end

        ST_SETTLE: begin
          if (reel_run != 3'b000) begin
            state <= ST_SPIN;
          end else begin
            settle_cnt <= settle_next;
            if (settle_next >= SETTLE_LAST) begin
              state <= ST_JUDGE;
            end
          end
        end

        ST_JUDGE: begin
          state     <= ST_SHOW;
          result    <= judge_result;
          credits   <= credits_paid;
          win_led   <= (judge_result != RES_LOSE);
          blink_cnt <= '0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slot_judge.sv
// -----------------------------------------------------------------------------
// tb_slot_judge
//   Directed bench for slot_judge. Three instances share one stimulus stream:
//   u_dut uses the defaults, u_zero starts with no credits, and u_sat starts at
//   253 credits with a short blink period. Inputs change 1 time unit after each
//   rising edge, and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_slot_judge;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [2:0] reel_run;
  logic [7:0] reel0, reel1, reel2;

  logic       busy, win_led;
  logic [1:0] result;
  logic [7:0] credits;

  logic       z_busy, z_win_led;
  logic [1:0] z_result;
  logic [7:0] z_credits;

  logic       s_busy, s_win_led;
  logic [1:0] s_result;
  logic [7:0] s_credits;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  slot_judge u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .reel_run(reel_run),
    .reel0(reel0), .reel1(reel1), .reel2(reel2),
    .busy(busy), .result(result), .win_led(win_led), .credits(credits)
  );

  slot_judge #(.INIT_CREDITS(0)) u_zero (
    .clk(clk), .reset_n(reset_n), .start(start), .reel_run(reel_run),
    .reel0(reel0), .reel1(reel1), .reel2(reel2),
    .busy(z_busy), .result(z_result), .win_led(z_win_led), .credits(z_credits)
  );

  slot_judge #(.INIT_CREDITS(253), .BLINK_BITS(3)) u_sat (
    .clk(clk), .reset_n(reset_n), .start(start), .reel_run(reel_run),
    .reel0(reel0), .reel1(reel1), .reel2(reel2),
    .busy(s_busy), .result(s_result), .win_led(s_win_led), .credits(s_credits)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_reels(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    reel0 = a;
    reel1 = b;
    reel2 = c;
  endtask

  initial begin
    logic seen_led;

    reset_n  = 1'b0;
    start    = 1'b0;
    reel_run = 3'b000;
    set_reels(8'h00, 8'h00, 8'h00);
    step(2);
    check("rst_busy",    busy,      0);
    check("rst_result",  result,    0);
    check("rst_win_led", win_led,   0);
    check("rst_credits", credits,   10);
    check("rst_z_cred",  z_credits, 0);
    check("rst_s_cred",  s_credits, 253);
    reset_n = 1'b1;

    // Game 1: triple 0x01/0x01/0x01.
    start    = 1'b1;
    reel_run = 3'b111;
    step(1);
    start = 1'b0;
    check("g1_busy",    busy,      1);
    check("g1_credits", credits,   9);
    check("g1_s_cred",  s_credits, 252);
    check("z_busy",     z_busy,    0);
    check("z_credits",  z_credits, 0);
    step(3);
    check("g1_spin_busy", busy, 1);
    set_reels(8'h01, 8'h01, 8'h01);
    reel_run = 3'b000;
    step(4);
    check("g1_judge_busy", busy, 1);
    step(1);
    check("g1_show_busy", busy,      0);
    check("g1_result",    result,    2);
    check("g1_paid",      credits,   14);
    check("g1_win_led",   win_led,   1);
    check("g1_s_sat",     s_credits, 255);
    check("g1_s_led",     s_win_led, 1);
    check("z_idle_busy",  z_busy,    0);

    // Blink of the 3-bit instance: 8 cycles high, 8 low, then high again.
    step(7);
    check("blink_hi_end", s_win_led, 1);
    step(1);
    check("blink_lo",     s_win_led, 0);
    check("blink_slow",   win_led,   1);
    step(7);
    check("blink_lo_end", s_win_led, 0);
    step(1);
    check("blink_hi2",    s_win_led, 1);

    // Game 2: pair 0x04/0x10/0x04, start taken from SHOW.
    set_reels(8'h04, 8'h10, 8'h04);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("g2_result_clr", result,    0);
    check("g2_led_clr",    win_led,   0);
    check("g2_credits",    credits,   13);
    check("g2_s_led_clr",  s_win_led, 0);
    check("g2_s_credits",  s_credits, 254);
    step(4);
    check("g2_judge_busy", busy, 1);
    step(1);
    check("g2_show_busy", busy,    0);
    check("g2_result",    result,  1);
    check("g2_net_zero",  credits, 14);
    check("g2_win_led",   win_led, 1);

    // Game 3: lose 0x01/0x02/0x04, with a start pulse held into SPIN.
    start    = 1'b1;
    reel_run = 3'b111;
    step(1);
    check("g3_credits", credits, 13);
    step(1);
    start = 1'b0;
    check("spin_start_cred", credits, 13);
    check("spin_start_busy", busy,    1);
    set_reels(8'h01, 8'h02, 8'h04);
    reel_run = 3'b000;
    step(5);
    check("g3_show_busy", busy,    0);
    check("g3_result",    result,  0);
    check("g3_credits_2", credits, 13);
    check("g3_win_led",   win_led, 0);
    seen_led = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (win_led) seen_led = 1'b1;
    end
    check("lose_led_100", seen_led, 0);
    check("lose_result",  result,   0);

    // Game 4: SETTLE interrupted after two stopped cycles.
    set_reels(8'h07, 8'h07, 8'h07);
    start    = 1'b1;
    reel_run = 3'b111;
    step(1);
    start = 1'b0;
    check("g4_credits", credits, 12);
    reel_run = 3'b000;
    step(2);
    reel_run = 3'b001;
    step(1);
    check("abort_busy", busy, 1);
    reel_run = 3'b000;
    step(4);
    check("abort_window", busy, 1);
    step(1);
    check("abort_show",    busy,    0);
    check("abort_result",  result,  2);
    check("abort_credits", credits, 17);

    // Reset in the middle of SETTLE: spent credit is not refunded.
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("g5_credits", credits, 16);
    step(2);
    check("g5_settle_busy", busy, 1);
    reset_n = 1'b0;
    step(1);
    check("mid_rst_busy",    busy,      0);
    check("mid_rst_credits", credits,   10);
    check("mid_rst_result",  result,    0);
    check("mid_rst_led",     win_led,   0);
    check("mid_rst_s_cred",  s_credits, 253);

    // First cycle out of reset accepts start.
    reset_n  = 1'b1;
    start    = 1'b1;
    reel_run = 3'b111;
    step(1);
    start = 1'b0;
    check("post_rst_busy",    busy,    1);
    check("post_rst_credits", credits, 9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
